uart_cmd_sequencer: RTL
=======================

UART_CMD_SEQUENCER -- requirements
Module: uart_cmd_sequencer

Interface
REQ-001 SHALL have clk, input, 1: clock; all logic rising-edge.
REQ-002 SHALL have reset, input, 1: reset, synchronous, active-high.
REQ-003 SHALL have cmd_strobe, input, 1: asynchronous host command strobe.
REQ-004 SHALL have cmd, input, 2: command code (0 DATA, 1 CONFIG, 2 PREDIV, 3 SPARE).
REQ-005 SHALL have payload, input, 5: command argument.
REQ-006 SHALL have tx_data, output, 8: byte offered to the UART transmitter.
REQ-007 SHALL have tx_valid, output, 1: tx_data valid.
REQ-008 SHALL have tx_ready, input, 1: transmitter accepts tx_data.
REQ-009 SHALL have prediv, output, 8: baud prescaler value.
REQ-010 SHALL have cfg, output, 3: {stop2, parity_odd, parity_en}.
REQ-011 SHALL have reset_cmd_strobe, output, 1: one-cycle soft-reset pulse.
REQ-012 SHALL have status, output, 8: {tx_valid, overrun, nib_pending, pend_is_prediv, 1'b0, cfg[2:0]}.

Function
REQ-013 SHALL synchronise cmd_strobe through 2 flops plus edge-detect flop; one command executes per rising edge, at the 3rd clk edge after the first edge sampling cmd_strobe high.
REQ-014 SHALL sample cmd/payload directly at the execute edge; host holds them stable >=4 clk around the strobe edge.
REQ-015 SHALL implement FSM states IDLE, NIB_LO (low nibble held), TX_WAIT (tx_valid high).
REQ-016 DATA in IDLE: store payload[3:0] as low nibble, nib_pending=1, pend_is_prediv=0, -> NIB_LO; payload[4] ignored.
REQ-017 DATA in NIB_LO with pend_is_prediv=0: tx_data={payload[3:0], low nibble}, tx_valid=1, nib_pending=0, -> TX_WAIT.
REQ-018 PREDIV: same two-write nibble sequence with pend_is_prediv=1; prediv updates atomically on the 2nd write only, -> IDLE.
REQ-019 DATA/PREDIV in NIB_LO whose kind differs from pend_is_prediv: discard held nibble, treat as a new 1st write.
REQ-020 TX_WAIT: tx_valid and tx_data held until the edge where tx_ready=1, then tx_valid=0 and -> IDLE.
REQ-021 DATA in TX_WAIT: dropped, overrun=1 (sticky); PREDIV/CONFIG in TX_WAIT execute normally without disturbing the pending byte.
REQ-022 CONFIG payload 5'b11000: reset_cmd_strobe=1 for exactly one cycle; in that same edge all state returns to reset values except reset_cmd_strobe.
REQ-023 CONFIG payload 5'b10000: clear overrun.
REQ-024 CONFIG payload[4]=0: cfg=payload[2:0]; payload[3] ignored; any nibble pending is kept.
REQ-025 Other CONFIG payloads and all SPARE commands: no effect.
REQ-026 tx_ready while tx_valid=0 SHALL be ignored.
REQ-027 Command execution and tx_ready acceptance in the same cycle SHALL both take effect (DATA 2nd write then lands in TX_WAIT is not overrun: handshake completes first).

Reset
REQ-028 On reset: FSM IDLE, tx_data=8'h00, tx_valid=0, prediv=8'h0C, cfg=3'b000, overrun=0, nib_pending=0, pend_is_prediv=0, reset_cmd_strobe=0, sync/edge flops 0.
REQ-029 Reset mid-operation SHALL abandon any held nibble or pending byte without a tx handshake.

Structure
REQ-030 Shared package uart_cmd_pkg SHALL hold command codes, CONFIG codes 5'b11000/5'b10000, FSM encoding, prediv reset 8'h0C.
REQ-031 Sub-module uart_strobe_sync SHALL contain the 2-flop synchroniser and rising-edge detector.

Verification
REQ-032 Reset, no strobe -> prediv=8'h0C, cfg=0, tx_valid=0, status=8'h00.
REQ-033 DATA 0x05, DATA 0x0A, tx_ready=0 -> tx_valid=1, tx_data=8'hA5 held; tx_ready=1 one cycle -> tx_valid=0 next edge.
REQ-034 PREDIV 0x03 then DATA 0x07, DATA 0x01 -> nibble discarded, tx_data=8'h17, prediv stays 8'h0C.
REQ-035 Byte pending, DATA 0x01 -> overrun=1, status[6]=1; CONFIG 5'b10000 -> overrun=0, pending byte unchanged.
REQ-036 CONFIG 5'b00101 -> cfg=3'b101; CONFIG 5'b11000 -> reset_cmd_strobe pulse 1 cycle, cfg=0, prediv=8'h0C.
REQ-037 Strobe held high 20 cycles -> exactly one command executes, at the 3rd edge.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Shared definitions for the UART command sequencer: command codes, CONFIG
// sub-codes, FSM encoding and reset constants.
package uart_cmd_pkg;

  typedef enum logic [1:0] {
    CMD_DATA   = 2'd0,
    CMD_CONFIG = 2'd1,
    CMD_PREDIV = 2'd2,
    CMD_SPARE  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_NIB_LO  = 2'd1,
    ST_TX_WAIT = 2'd2
  } state_e;

  localparam logic [4:0] CFG_SOFT_RESET  = 5'b11000;
  localparam logic [4:0] CFG_CLR_OVERRUN = 5'b10000;
  localparam logic [7:0] PREDIV_RST      = 8'h0C;

  // The first write of a pair always supplies the low nibble.
  function automatic logic [7:0] join_nibbles(input logic [3:0] hi, input logic [3:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_cmd_sequencer_if.sv
// Host command port and UART transmit/status signals of the command sequencer.
interface uart_cmd_sequencer_if;
  import uart_cmd_pkg::*;

  logic       cmd_strobe;
  logic [1:0] cmd;
  logic [4:0] payload;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] prediv;
  logic [2:0] cfg;
  logic       reset_cmd_strobe;
  logic [7:0] status;

  modport master (
    output cmd_strobe, cmd, payload, tx_ready,
    input  tx_data, tx_valid, prediv, cfg, reset_cmd_strobe, status
  );

  modport slave (
    input  cmd_strobe, cmd, payload, tx_ready,
    output tx_data, tx_valid, prediv, cfg, reset_cmd_strobe, status
  );

endinterface

// File: rtl/uart_strobe_sync.sv
// Two-flop synchroniser for the asynchronous host strobe followed by a
// rising-edge detector producing a single-cycle execute pulse.
module uart_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_pulse
);

  logic r_meta_p0;
  logic r_sync_p1;
  logic r_prev_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_meta_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
      r_prev_p2 <= 1'b0;
    end else begin
      r_meta_p0 <= i_async;
      r_sync_p1 <= r_meta_p0;
      r_prev_p2 <= r_sync_p1;
    end
  end

  assign o_pulse = r_sync_p1 & ~r_prev_p2;

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Decodes synchronised host commands into UART transmit bytes, prescaler and
// line configuration, with a two-write nibble protocol for 8-bit values.
module uart_cmd_sequencer
  import uart_cmd_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  uart_cmd_sequencer_if.slave bus
);

  logic w_exec;

  uart_strobe_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .i_async (bus.cmd_strobe),
    .o_pulse (w_exec)
  );

  state_e     r_state, w_state_n;
  logic [7:0] r_tx_data, w_tx_data_n;
  logic       r_tx_valid, w_tx_valid_n;
  logic [7:0] r_prediv, w_prediv_n;
  logic [2:0] r_cfg, w_cfg_n;
  logic       r_overrun, w_overrun_n;
  logic       r_nib_pending, w_nib_pending_n;
  logic       r_pend_is_prediv, w_pend_is_prediv_n;
  logic [3:0] r_nib_lo, w_nib_lo_n;
  logic       r_rst_strobe, w_rst_strobe_n;

  always_comb begin
    w_tx_data_n        = r_tx_data;
    w_tx_valid_n       = r_tx_valid;
    w_prediv_n         = r_prediv;
    w_cfg_n            = r_cfg;
    w_overrun_n        = r_overrun;
    w_nib_pending_n    = r_nib_pending;
    w_pend_is_prediv_n = r_pend_is_prediv;
    w_nib_lo_n         = r_nib_lo;
    w_rst_strobe_n     = 1'b0;

    // Handshake resolves first so a command in the same cycle sees the slot free.
    if (r_state == ST_TX_WAIT && bus.tx_ready)
      w_tx_valid_n = 1'b0;

    if (w_exec) begin
      unique case (cmd_e'(bus.cmd))
        CMD_DATA: begin
          if (w_tx_valid_n) begin
            w_overrun_n = 1'b1;
          end else if (r_nib_pending && !r_pend_is_prediv) begin
            w_tx_data_n     = join_nibbles(bus.payload[3:0], r_nib_lo);
            w_tx_valid_n    = 1'b1;
            w_nib_pending_n = 1'b0;
          end else begin
            w_nib_lo_n         = bus.payload[3:0];
            w_nib_pending_n    = 1'b1;
            w_pend_is_prediv_n = 1'b0;
          end
        end
        CMD_PREDIV: begin
          if (r_nib_pending && r_pend_is_prediv) begin
            w_prediv_n         = join_nibbles(bus.payload[3:0], r_nib_lo);
            w_nib_pending_n    = 1'b0;
            w_pend_is_prediv_n = 1'b0;
          end else begin
            w_nib_lo_n         = bus.payload[3:0];
            w_nib_pending_n    = 1'b1;
            w_pend_is_prediv_n = 1'b1;
          end
        end
        CMD_CONFIG: begin
          // Soft reset leaves the strobe synchroniser alone so a still-high
          // host strobe cannot re-trigger the same command.
          if (bus.payload == CFG_SOFT_RESET) begin
            w_tx_data_n        = 8'h00;
            w_tx_valid_n       = 1'b0;
            w_prediv_n         = PREDIV_RST;
            w_cfg_n            = 3'b000;
            w_overrun_n        = 1'b0;
            w_nib_pending_n    = 1'b0;
            w_pend_is_prediv_n = 1'b0;
            w_nib_lo_n         = 4'h0;
            w_rst_strobe_n     = 1'b1;
          end else if (bus.payload == CFG_CLR_OVERRUN) begin
            w_overrun_n = 1'b0;
          end else if (!bus.payload[4]) begin
            w_cfg_n = bus.payload[2:0];
          end
        end
        CMD_SPARE: ;
      endcase
    end

    if (w_tx_valid_n)         w_state_n = ST_TX_WAIT;
    else if (w_nib_pending_n) w_state_n = ST_NIB_LO;
    else                      w_state_n = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_IDLE;
      r_tx_data        <= 8'h00;
      r_tx_valid       <= 1'b0;
      r_prediv         <= PREDIV_RST;
      r_cfg            <= 3'b000;
      r_overrun        <= 1'b0;
      r_nib_pending    <= 1'b0;
      r_pend_is_prediv <= 1'b0;
      r_nib_lo         <= 4'h0;
      r_rst_strobe     <= 1'b0;
    end else begin
      r_state          <= w_state_n;
      r_tx_data        <= w_tx_data_n;
      r_tx_valid       <= w_tx_valid_n;
      r_prediv         <= w_prediv_n;
      r_cfg            <= w_cfg_n;
      r_overrun        <= w_overrun_n;
      r_nib_pending    <= w_nib_pending_n;
      r_pend_is_prediv <= w_pend_is_prediv_n;
      r_nib_lo         <= w_nib_lo_n;
      r_rst_strobe     <= w_rst_strobe_n;
    end
  end

  assign bus.tx_data          = r_tx_data;
  assign bus.tx_valid         = r_tx_valid;
  assign bus.prediv           = r_prediv;
  assign bus.cfg              = r_cfg;
  assign bus.reset_cmd_strobe = r_rst_strobe;
  assign bus.status           = {r_tx_valid, r_overrun, r_nib_pending, r_pend_is_prediv,
                                 1'b0, r_cfg};

endmodule
